// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, sync level encodings and helpers
// used by the display timing generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned MAX_TOTAL     = 1024;
    localparam int unsigned MAX_DELAY     = 7;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        logic vsync;
        logic hsync;
        logic video;
    } sync_bits_t;

    function automatic int unsigned timing_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

    function automatic sync_bits_t sync_idle(input logic pol);
        sync_bits_t s;
        s.vsync = ~pol;
        s.hsync = ~pol;
        s.video = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Async-reset shift register with a per-bit reset value; depth 0 is a
// straight pass-through.
module sync_delay_line #(
    parameter int unsigned        DEPTH   = 2,
    parameter int unsigned        WIDTH   = 3,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_clk_reset;
            assign unused_clk_reset = clk ^ reset;
            assign dout = din;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        stage[i] <= RST_VAL;
                    end
                end else begin
                    stage[0] <= din;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running display timing generator: pixel coordinates, line/frame
// strobes, and sync/video flags delayed to match the sprite pipelines.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter logic        SYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int unsigned SYNC_DELAY = 2
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] pix_row,
    output logic [9:0] pix_col,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_tick,
    output logic       frame_tick
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || SYNC_DELAY > MAX_DELAY) begin : g_param_check
            $error("vga_timing_gen: totals must not exceed 1024 and SYNC_DELAY must be 0..7");
        end
    endgenerate

    // Decode thresholds are 11 bits so a 1024-wide total cannot wrap them.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_bits_t SYNC_IDLE = sync_idle(SYNC_POL);

    logic [9:0]  h;
    logic [9:0]  v;
    logic [10:0] hx;
    logic [10:0] vx;
    sync_bits_t  sync_raw;
    sync_bits_t  sync_reg;
    sync_bits_t  sync_out;

    assign hx = {1'b0, h};
    assign vx = {1'b0, v};

    always_comb begin
        sync_raw = SYNC_IDLE;
        if (hx >= HS_START && hx < HS_END) begin
            sync_raw.hsync = SYNC_POL;
        end
        if (vx >= VS_START && vx < VS_END) begin
            sync_raw.vsync = SYNC_POL;
        end
        sync_raw.video = (hx < H_ACT) && (vx < V_ACT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h          <= '0;
            v          <= '0;
            pix_row    <= '0;
            pix_col    <= '0;
            line_tick  <= 1'b0;
            frame_tick <= 1'b0;
            sync_reg   <= SYNC_IDLE;
        end else begin
            pix_col    <= h;
            pix_row    <= v;
            line_tick  <= (h == '0);
            frame_tick <= (vx == V_ACT) && (h == '0);
            sync_reg   <= sync_raw;
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // sync_reg already shares the coordinate register stage, so the line
    // adds exactly SYNC_DELAY cycles on top of the coordinates.
    sync_delay_line #(
        .DEPTH   (SYNC_DELAY),
        .WIDTH   (3),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .reset (reset),
        .din   (sync_reg),
        .dout  (sync_out)
    );

    assign hsync    = sync_out.hsync;
    assign vsync    = sync_out.vsync;
    assign video_on = sync_out.video;

endmodule
